// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
//
// Measurement bundle published by pwm_capture toward the status registers.
//
// Parameters:
//    CTR_WIDTH    width of both measurement fields
//
// Signals:
//    level         synchronized copy of the PWM input
//    high_count    high time of the last complete period, in samples
//    period_count  total length of the last complete period, in samples
//    valid         one-cycle strobe, measurement fields changed this cycle
//    stuck_high    sticky: input high too long / continuous 100% duty
//    stuck_low     sticky: input low too long / continuous 0% duty
//
// Modports:
//    master  the capture block, drives every field
//    slave   the consumer (status registers), reads every field
// ---------------------------------------------------------------------------
interface pwm_capture_if #(
   parameter int CTR_WIDTH = 12
);

   logic                 level;
   logic [CTR_WIDTH-1:0] high_count;
   logic [CTR_WIDTH-1:0] period_count;
   logic                 valid;
   logic                 stuck_high;
   logic                 stuck_low;

   modport master (
      output level,
      output high_count,
      output period_count,
      output valid,
      output stuck_high,
      output stuck_low
   );

   modport slave (
      input level,
      input high_count,
      input period_count,
      input valid,
      input stuck_high,
      input stuck_low
   );

endinterface

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Samples an asynchronous single-bit PWM waveform and measures, for every
// complete period, the number of high samples and the total number of
// samples.  A period runs from one rising-edge sample (inclusive) to the
// next rising-edge sample (exclusive).  Each finished period is published
// as a registered measurement together with a one-cycle valid strobe.
// Waveforms that stay high or low longer than the counter can express raise
// a sticky stuck flag instead of producing a measurement.
//
// Parameters:
//    CTR_WIDTH    width of the sample counter and both measurement outputs
//    SYNC_STAGES  flops in the input synchronizer chain (minimum 2)
//
// Ports:
//    clk      system clock, single clock domain
//    rst      synchronous active-high reset
//    pwm_in   asynchronous PWM input
//    meas     measurement bundle (master side): level, high_count,
//             period_count, valid, stuck_high, stuck_low
// ---------------------------------------------------------------------------
module pwm_capture #(
   parameter int CTR_WIDTH   = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   pwm_capture_if.master    meas
);

   // Largest counter value, and the value one below it.  A high phase may
   // last at most MAX-1 samples and a full period at most MAX samples, so
   // the counter is never allowed to wrap.
   localparam logic [CTR_WIDTH-1:0] CNT_MAX    = {CTR_WIDTH{1'b1}};
   localparam logic [CTR_WIDTH-1:0] CNT_MAX_M1 = {{(CTR_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [CTR_WIDTH-1:0] CNT_ONE    = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_s;
   logic                   rise;
   logic                   fall;

   logic [CTR_WIDTH-1:0]   cnt_q;
   logic [CTR_WIDTH-1:0]   cnt_d;
   logic [CTR_WIDTH-1:0]   h_q;
   logic [CTR_WIDTH-1:0]   h_d;
   logic [CTR_WIDTH-1:0]   high_q;
   logic [CTR_WIDTH-1:0]   high_d;
   logic [CTR_WIDTH-1:0]   period_q;
   logic [CTR_WIDTH-1:0]   period_d;
   logic                   valid_q;
   logic                   valid_d;
   logic                   stuck_high_q;
   logic                   stuck_high_d;
   logic                   stuck_low_q;
   logic                   stuck_low_d;

   // Input synchronizer followed by a one-sample history flop.  The chain
   // is cleared by reset so that a level already high on the pad appears as
   // a fresh rise afterwards.  New samples enter at bit 0 and the oldest
   // synchronized sample sits at the top bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge detection on the synchronized sample stream.
   always_comb begin
      sync_s = sync_q[SYNC_STAGES-1];
      rise   = sync_s & ~prev_q;
      fall   = ~sync_s & prev_q;
   end

   // State, counter and measurement registers.  Reset wins over anything
   // the next-state logic wants to do in the same cycle, including closing
   // a period on a simultaneous rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARM;
         cnt_q        <= '0;
         h_q          <= '0;
         high_q       <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         h_q          <= h_d;
         high_q       <= high_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         stuck_high_q <= stuck_high_d;
         stuck_low_q  <= stuck_low_d;
      end
   end

   // Measurement FSM.
   //    ARM  waits for a rise; whatever came before it is a partial period
   //         and is thrown away.
   //    HIGH counts high samples; the fall latches the high time.
   //    LOW  counts low samples; the next rise publishes the measurement
   //         and immediately starts timing the following period.
   // The counter holds the number of samples seen since the opening rise,
   // including the sample currently being processed once it is updated.
   // The stuck checks look at the count before the increment so that the
   // counter stops exactly at its limit and never wraps.  Raising one stuck
   // flag drops the other, and a successful measurement drops both.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      h_d          = h_q;
      high_d       = high_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      stuck_high_d = stuck_high_q;
      stuck_low_d  = stuck_low_q;

      case (state_q)
         ARM: begin
            if (rise) begin
               state_d = HIGH;
               cnt_d   = CNT_ONE;
            end
         end

         HIGH: begin
            if (fall) begin
               h_d     = cnt_q;
               cnt_d   = cnt_q + CNT_ONE;
               state_d = LOW;
            end else if (cnt_q == CNT_MAX_M1) begin
               stuck_high_d = 1'b1;
               stuck_low_d  = 1'b0;
               cnt_d        = '0;
               state_d      = ARM;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         LOW: begin
            if (rise) begin
               high_d       = h_q;
               period_d     = cnt_q;
               valid_d      = 1'b1;
               stuck_high_d = 1'b0;
               stuck_low_d  = 1'b0;
               cnt_d        = CNT_ONE;
               state_d      = HIGH;
            end else if (cnt_q == CNT_MAX) begin
               stuck_low_d  = 1'b1;
               stuck_high_d = 1'b0;
               cnt_d        = '0;
               state_d      = ARM;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ARM;
            cnt_d   = '0;
         end
      endcase
   end

   // Every output comes straight from a flop.
   assign meas.level        = sync_s;
   assign meas.high_count   = high_q;
   assign meas.period_count = period_q;
   assign meas.valid        = valid_q;
   assign meas.stuck_high   = stuck_high_q;
   assign meas.stuck_low    = stuck_low_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-side counterpart to the RGB PWM LED driver. It samples an asynchronous single-bit PWM waveform, such as a fan tach, an external dimmer or a looped-back LED drive, and measures each period's high time and total period in `clk` cycles. Each completed period is published as a registered measurement with a one-cycle `valid` strobe. The block sits between an input pad and the bus-visible status registers.

## Interface
Parameters:
- `CTR_WIDTH`, default 12: width of the cycle counter and of both measurement outputs.
- `SYNC_STAGES`, default 2: number of flops in the input synchronizer chain; minimum 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `pwm_in`  in  1  asynchronous PWM input.
- `level`  out  1  synchronized copy of `pwm_in` (last synchronizer stage).
- `high_count`  out  CTR_WIDTH  high time of the last complete period, in samples.
- `period_count`  out  CTR_WIDTH  total length of the last complete period, in samples.
- `valid`  out  1  one-cycle strobe; the measurement outputs changed this cycle.
- `stuck_high`  out  1  sticky flag: input high too long, or continuous 100% duty.
- `stuck_low`  out  1  sticky flag: input low too long, or continuous 0% duty.

## Operation
- Synchronizer: `SYNC_STAGES` flops, followed by one `prev` flop. Every one of these flops resets to 0.
  - `rise` = sync & ~prev.
  - `fall` = ~sync & prev.
- Period definition: a period runs from one rising-edge sample (inclusive) to the next rising-edge sample (exclusive).
  - If the synchronized input shows H high samples followed by L low samples, the block reports `high_count` = H and `period_count` = H+L.
- Sample counter `cnt` is CTR_WIDTH bits. It is set to 1 on the `rise` sample and incremented on every later sample.
- MAX = 2^CTR_WIDTH − 1.
- FSM states: ARM, HIGH, LOW.
- ARM is the reset state. It discards any partial period.
  - On `rise`: go to HIGH, `cnt` ← 1.
- HIGH:
  - On `fall`: latch internal `h` ← `cnt`, go to LOW, increment `cnt`.
  - Else if `cnt` == MAX−1 (the (2^W−1)th sample since the rise is still high): set `stuck_high` and go to ARM. No `valid` is produced.
- LOW:
  - On `rise`: `high_count` ← `h`, `period_count` ← `cnt`, `valid` = 1, `cnt` ← 1, stay in the measuring path by going to HIGH.
  - Else if `cnt` == MAX (the 2^W-th sample since the rise is not a rise): set `stuck_low` and go to ARM. No `valid` is produced.
- Stuck flags:
  - Both flags clear in the same cycle as the next `valid`.
  - `stuck_high` and `stuck_low` are never both 1. Setting one clears the other.
- Held values: `high_count` and `period_count` keep their last values between strobes.
- First measurement: after reset or after any stuck event, the first `valid` comes on the second detected rise.
- Reset mid-operation: `rst` overrides everything, including a `rise` in the same cycle. All state returns to its reset values.
- Arithmetic: `cnt` never wraps. The stuck checks fire before overflow.
  - Valid ranges: `high_count` from 1 to MAX−1, `period_count` from 2 to MAX.

## Timing
- Reset values: `level`=0, `high_count`=0, `period_count`=0, `valid`=0, `stuck_high`=0, `stuck_low`=0; FSM in ARM; `cnt`=0.
- Latency: let edge N be the first `clk` edge at which `pwm_in` is sampled high for the rising edge that closes a period.
  - `valid` and the new `high_count`/`period_count` are visible after edge N+SYNC_STAGES.
  - With the default `SYNC_STAGES` = 2 this is edge N+2.
- `level` follows `pwm_in` with a latency of SYNC_STAGES edges.
- `valid` is high for exactly one cycle per completed period.
- Minimum measurable waveform: H=1, L=1 (period 2). This yields one `valid` every 2 cycles.
- The block has no backpressure. A consumer that misses a strobe loses that measurement; the held outputs still show the latest one.
- Input transitions narrower than one `clk` period are measured only if a sample catches them.

## Test plan
Scenarios assume `CTR_WIDTH`=8 (MAX=255) and `SYNC_STAGES`=2.

1. **Steady waveform.** Release reset, then drive `pwm_in` 3 high / 5 low, repeating. Required: no `valid` for the first period; then `valid` exactly once every 8 cycles with `high_count`=3 and `period_count`=8. Check the latency of `valid` is edge N+2 from the rising sample.
2. **Narrowest pulses.** Drive 1 high / 1 low, repeating. Required: after arming, `valid` every 2 cycles with `high_count`=1 and `period_count`=2.
3. **Stuck high and recovery.** Hold `pwm_in` high for 300 cycles. Required: `stuck_high`=1 when the 255th high sample is processed, and no `valid`. Then drive 10 high / 20 low. Required: after one arming rise, `valid` with 10/30, and `stuck_high` clears on that strobe.
4. **Period boundary.** Drive 100 high / 155 low. Required: `period_count`=255 and `valid` pulses. Then drive 100 high / 156 low. Required: `stuck_low`=1 and no `valid`, with `high_count`/`period_count` still holding 100/255.
5. **Reset mid-period.** Assert `rst` for 1 cycle during the HIGH phase of a 4/4 waveform. Required: all outputs 0 on the next cycle; the first post-reset `valid` (4/8) appears only after two rises.
6. **Reset racing an edge.** Assert `rst` in the same cycle as `rise` is detected in LOW. Required: no `valid`, and the measurement outputs are cleared to 0.
